// File: rtl/fmul_arb_if.sv
// fmul_arb_if: request/result bundle between FP requesters and the shared fmul arbiter.
interface fmul_arb_if #(parameter int NREQ = 2);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_y;
    logic               res_ovf;
    logic [IDW-1:0]     res_id;
    modport master(output req_valid, req_x1, req_x2, res_ready,
                   input req_ready, res_valid, res_y, res_ovf, res_id);
    modport slave(input req_valid, req_x1, req_x2, res_ready,
                  output req_ready, res_valid, res_y, res_ovf, res_id);
endinterface

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin share of one truncating fmul, operand reg -> fmul -> result reg.
// Define FMUL_ARB_STATS_EN to add the stat_issued / stat_stall counters.
module fmul_arbiter #(parameter int NREQ = 2) (
    input logic clk,
    input logic rst,
    fmul_arb_if.slave bus
`ifdef FMUL_ARB_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
`endif
);
    localparam int IDW = $clog2(NREQ);
    logic           s1_valid, s2_valid, s2_ovf;
    logic [31:0]    s1_x1, s1_x2, s2_y;
    logic [IDW-1:0] s1_id, s2_id, rr_ptr, grant_id;
    logic           adv1, adv2, grant_hit;
    logic [31:0]    g_x1, g_x2, fm_y;
    logic           fm_ovf, fm_zero;
    logic [47:0]    mp;
    logic signed [9:0] ex;
    int             idx;
    assign adv2 = !s2_valid || bus.res_ready;
    assign adv1 = !s1_valid || adv2;
    // Walk downward so the candidate nearest rr_ptr is the last one written and wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_id = '0;
        g_x1 = '0;
        g_x2 = '0;
        idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (adv1 && bus.req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id = IDW'(idx);
                g_x1 = bus.req_x1[32*idx +: 32];
                g_x2 = bus.req_x2[32*idx +: 32];
            end
        end
    end
    assign bus.req_ready = grant_hit ? {{(NREQ-1){1'b0}}, 1'b1} << grant_id : '0;
    // Truncating multiply: zero on underflow or zero-exponent input, signed infinity on overflow.
    always_comb begin
        mp = {24'b0, 1'b1, s1_x1[22:0]} * {24'b0, 1'b1, s1_x2[22:0]};
        ex = $signed({2'b0, s1_x1[30:23]} + {2'b0, s1_x2[30:23]} + {9'b0, mp[47]}) - 10'sd127;
        fm_zero = s1_x1[30:23] == 8'd0 || s1_x2[30:23] == 8'd0 || ex <= 10'sd0;
        fm_ovf = !fm_zero && ex >= 10'sd255;
        fm_y = fm_zero ? 32'd0
             : fm_ovf ? {s1_x1[31] ^ s1_x2[31], 8'hff, 23'd0}
             : {s1_x1[31] ^ s1_x2[31], ex[7:0], mp[47] ? mp[46:24] : mp[45:23]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x1 <= '0;
            s1_x2 <= '0;
            s1_id <= '0;
            s2_valid <= 1'b0;
            s2_y <= '0;
            s2_ovf <= 1'b0;
            s2_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_y <= fm_y;
                s2_ovf <= fm_ovf;
                s2_id <= s1_id;
            end
            if (adv1) begin
                s1_valid <= grant_hit;
                s1_x1 <= g_x1;
                s1_x2 <= g_x2;
                s1_id <= grant_id;
            end
            if (grant_hit)
                rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
    assign bus.res_valid = s2_valid;
    assign bus.res_y = s2_y;
    assign bus.res_ovf = s2_ovf;
    assign bus.res_id = s2_id;
`ifdef FMUL_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall <= '0;
        end else begin
            if (grant_hit)
                stat_issued <= stat_issued + 1'b1;
            if (|bus.req_valid && !(|bus.req_ready))
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: scoreboard bench for fmul_arbiter (directed scenarios plus random traffic).
module tb_fmul_arbiter;
    localparam int NREQ = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fmul_arb_if #(.NREQ(NREQ)) bus();
`ifdef FMUL_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif
    fmul_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef FMUL_ARB_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall(stat_stall)
`endif
    );
    typedef struct { int id; logic [31:0] x1; logic [31:0] x2; } req_t;
    typedef struct { int id; logic [31:0] y; logic ovf; } res_t;
    req_t exp_q[$];
    res_t got_q[$];
    int vectors = 0;
    int errors = 0;
    int grants = 0;
    localparam logic [31:0] OP_A = 32'h3FC00000, OP_B = 32'h40000000, OP_C = 32'h40400000;

    // Runs one clock from a negedge: records grants and accepted results just before the edge.
    task automatic cycle();
        req_t q;
        res_t r;
        #3;
        for (int k = 0; k < NREQ; k++)
            if (bus.req_ready[k]) begin
                q.id = k;
                q.x1 = bus.req_x1[32*k +: 32];
                q.x2 = bus.req_x2[32*k +: 32];
                exp_q.push_back(q);
            end
        if (bus.res_valid && bus.res_ready) begin
            r.id = int'(bus.res_id);
            r.y = bus.res_y;
            r.ovf = bus.res_ovf;
            got_q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        bus.req_x1[32*k +: 32] = a;
        bus.req_x2[32*k +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        cycle();
        cycle();
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit done;
        set_req(k, a, b);
        bus.req_valid[k] = 1'b1;
        n = exp_q.size();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = exp_q.size() > n;
        end
        bus.req_valid[k] = 1'b0;
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL issue_grant req=%0d got=no_grant expected=grant", k);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 50 && got_q.size() < n; i++)
            cycle();
        vectors++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL drain_timeout got=%0d expected=%0d", got_q.size(), n);
        end
    endtask

    function automatic real s2r(input logic [31:0] x);
        return $bitstoreal({x[31], 3'b000, x[30:23] + 8'd0, x[22:0], 29'd0} + 64'h3800_0000_0000_0000);
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    task automatic test_reset();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        bus.req_x1 = '0;
        bus.req_x2 = '0;
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.res_y !== 32'd0 || bus.res_ovf !== 1'b0 || bus.res_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h/%b/%0d expected=0/00000000/0/0", bus.res_valid, bus.res_y, bus.res_ovf, bus.res_id);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle_ready got=%b expected=00", bus.req_ready);
        end
        cycle();
    endtask

    task automatic test_single();
        bus.res_ready = 1'b1;
        set_req(0, OP_A, OP_B);
        bus.req_valid = 2'b01;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got=%b expected=01", bus.req_ready);
        end
        cycle();
        bus.req_valid = '0;
        #1;
        vectors++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early got=%b expected=0", bus.res_valid);
        end
        cycle();
        #1;
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.res_y !== 32'h40400000 || bus.res_ovf !== 1'b0 || bus.res_id !== 1'b0) begin
            errors++;
            $display("FAIL single_result got=%b/%h/%b/%0d expected=1/40400000/0/0", bus.res_valid, bus.res_y, bus.res_ovf, bus.res_id);
        end
        cycle();
        #1;
        vectors++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drained got=%b expected=0", bus.res_valid);
        end
        cycle();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_ovf_unf();
        bus.res_ready = 1'b1;
        issue(1, 32'h7F000000, 32'h7F000000);
        issue(0, 32'h00800000, 32'h00800000);
        drain(2);
        if (got_q.size() >= 2) begin
            vectors++;
            if (got_q[0].ovf !== 1'b1 || got_q[0].y[30:23] !== 8'hff || got_q[0].id != 1) begin
                errors++;
                $display("FAIL overflow got=%b/%h/%0d expected=1/exp255/1", got_q[0].ovf, got_q[0].y, got_q[0].id);
            end
            vectors++;
            if (got_q[1].y !== 32'd0 || got_q[1].ovf !== 1'b0 || got_q[1].id != 0) begin
                errors++;
                $display("FAIL underflow got=%h/%b/%0d expected=00000000/0/0", got_q[1].y, got_q[1].ovf, got_q[1].id);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.res_ready = 1'b1;
        set_req(0, OP_A, OP_B);
        set_req(1, OP_B, OP_B);
        bus.req_valid = 2'b11;
        repeat (6) cycle();
        bus.req_valid = '0;
        drain(6);
        vectors++;
        if (exp_q.size() != 6) begin
            errors++;
            $display("FAIL rr_grant_count got=%0d expected=6", exp_q.size());
        end
        for (int i = 0; i < 6 && i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (exp_q[i].id != i % 2 || got_q[i].id != i % 2 || got_q[i].y !== ((i % 2) ? 32'h40800000 : 32'h40400000)) begin
                errors++;
                $display("FAIL rr_order[%0d] got=grant%0d/res%0d/%h expected=%0d/%0d/%h", i, exp_q[i].id, got_q[i].id, got_q[i].y, i % 2, i % 2, (i % 2) ? 32'h40800000 : 32'h40400000);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [3];
        logic [31:0] want [3];
        int idx;
        int n;
        ops = '{OP_A, OP_B, OP_C};
        want = '{32'h40400000, 32'h40800000, 32'h40C00000};
        bus.res_ready = 1'b0;
        idx = 0;
        set_req(0, ops[0], OP_B);
        bus.req_valid = 2'b01;
        for (int c = 0; c < 6; c++) begin
            n = exp_q.size();
            cycle();
            if (exp_q.size() > n && idx < 2) begin
                idx++;
                set_req(0, ops[idx], OP_B);
            end
        end
        #1;
        vectors++;
        if (exp_q.size() != 2 || bus.req_ready !== 2'b00 || bus.res_valid !== 1'b1 || bus.res_y !== want[0]) begin
            errors++;
            $display("FAIL bp_full got=acc%0d/rdy%b/v%b/%h expected=acc2/rdy00/v1/%h", exp_q.size(), bus.req_ready, bus.res_valid, bus.res_y, want[0]);
        end
        cycle();
        cycle();
        bus.res_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01 || bus.res_y !== want[0]) begin
            errors++;
            $display("FAIL bp_release got=rdy%b/%h expected=rdy01/%h", bus.req_ready, bus.res_y, want[0]);
        end
        cycle();
        bus.req_valid = '0;
        drain(3);
        repeat (3) cycle();
        vectors++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bp_count got=res%0d/acc%0d expected=3/3", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].y !== want[i] || got_q[i].id != 0) begin
                errors++;
                $display("FAIL bp_order[%0d] got=%h/%0d expected=%h/0", i, got_q[i].y, got_q[i].id, want[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        bus.res_ready = 1'b0;
        set_req(0, OP_A, OP_B);
        set_req(1, OP_B, OP_B);
        bus.req_valid = 2'b11;
        cycle();
        cycle();
        #1;
        vectors++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_prefill got=%b expected=1", bus.res_valid);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        #1;
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_state got=v%b/rdy%b expected=v0/rdy01", bus.res_valid, bus.req_ready);
        end
        cycle();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (5) cycle();
        vectors++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0].id != 0)) begin
            errors++;
            $display("FAIL rstmid_results got=%0d expected=1 from requester 0", got_q.size());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] pa [NREQ];
        logic [31:0] pb [NREQ];
        req_t e;
        res_t r;
        real p;
        logic [63:0] bits;
        logic [31:0] t;
        int re, n, k, cyc;
        bit ok;
        do_reset();
        grants = 0;
        cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = rnd_op();
            pb[i] = rnd_op();
        end
        while ((grants < 10000 || got_q.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, pa[i], pb[i]);
                bus.req_valid[i] = grants < 10000 && $urandom_range(0, 3) != 0;
            end
            bus.res_ready = $urandom_range(0, 3) != 0;
            n = exp_q.size();
            cycle();
            cyc++;
            if (exp_q.size() > n) begin
                k = exp_q[$].id;
                grants++;
                pa[k] = rnd_op();
                pb[k] = rnd_op();
            end
            while (got_q.size() > 0) begin
                r = got_q.pop_front();
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got=id%0d/%h expected=no_result", r.id, r.y);
                    continue;
                end
                e = exp_q.pop_front();
                p = s2r(e.x1) * s2r(e.x2);
                bits = $realtobits(p);
                re = int'(bits[62:52]) - 896;
                t = {bits[63], re[7:0], bits[51:29]};
                if (re <= 0)
                    ok = r.y === 32'd0 && r.ovf === 1'b0;
                else if (re >= 255)
                    ok = r.ovf === 1'b1 && r.y[30:23] === 8'hff;
                else
                    ok = r.ovf === 1'b0 && (r.y === t || r.y === t + 32'd1);
                if (!ok || r.id != e.id) begin
                    errors++;
                    $display("FAIL rnd_result x1=%h x2=%h got=id%0d/%h/%b expected=id%0d/%h(+1ulp)/exp%0d", e.x1, e.x2, r.id, r.y, r.ovf, e.id, t, re);
                end
            end
        end
        bus.req_valid = '0;
        vectors++;
        if (grants != 10000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_complete got=grants%0d/pending%0d expected=10000/0", grants, exp_q.size());
        end
`ifdef FMUL_ARB_STATS_EN
        vectors++;
        if (stat_issued !== 32'(grants)) begin
            errors++;
            $display("FAIL stat_issued got=%0d expected=%0d", stat_issued, grants);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_ovf_unf();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one combinational fmul instance among NREQ requesters (e.g. integer-pipe FP issue and vector/loader paths).
- Round-robin arbitration, two-stage registered pipeline: operand register, fmul, result register.
- Single result channel with backpressure; each result carries the requester id.
- Sits between the FP issue logic and the shared fmul datapath.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester id field (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_x1  in  32*NREQ  operand 1, IEEE single; requester k occupies bits [32k+31:32k]
- req_x2  in  32*NREQ  operand 2, same packing as req_x1
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_y  out  32  product as produced by fmul
- res_ovf  out  1  fmul overflow flag
- res_id  out  IDW  index of the requester that issued this result

Behaviour:
- Reset (rst=1 at posedge): s1_valid=0, s2_valid=0, rr_ptr=0, res_valid=0, res_y=0, res_ovf=0, res_id=0. rst has priority over every other event; in-flight operations are discarded and no result is emitted for them.
- Pipeline regs: S1 = {s1_valid, x1, x2, id}; S2 = {s2_valid, y, ovf, id}. fmul is fed combinationally from S1 and its output is captured into S2.
- Advance conditions:
  - adv2 = !s2_valid | res_ready.
  - adv1 = !s1_valid | adv2.
- S2 update when adv2: s2_valid<=s1_valid; y/ovf/id <= fmul(S1)/S1.id.
- S2 when !adv2: holds; outputs stay stable while res_valid=1 and res_ready=0.
- S1 loads the granted request when adv1. If no request is granted, s1_valid<=0 when adv1. S1 holds when !adv1.
- Arbitration (combinational, only when adv1=1):
  - Search from rr_ptr upward, wrapping modulo NREQ; first k with req_valid[k]=1 wins.
  - req_ready[k]=1 for the winner only. When adv1=0, req_ready=0.
  - req_ready may depend on req_valid, so requesters must not make req_valid depend on req_ready.
- rr_ptr update: on a grant to k, rr_ptr<=(k+1) mod NREQ, wrapping NREQ-1 to 0. Unchanged with no grant.
- Latency: request accepted at edge T → res_valid=1 after edge T+1 if res_ready remained 1. Throughput is 1 result/cycle with continuous res_ready.
- Backpressure: with res_ready=0 the pipe fills (2 entries), then req_ready=0 to all. The first cycle res_ready returns to 1, S2 drains, S1 moves, and a new grant occurs in the same cycle (no bubble).
- Fairness: with all requesters continuously valid, grants are strictly cyclic 0,1,..,NREQ-1,0.
- Arithmetic: no modification of fmul output. res_y/res_ovf equal fmul(x1,x2) exactly, including y=0 on underflow and ovf=1 when the result exponent saturates to 255.
- A requester dropping req_valid without a grant is legal; nothing is recorded.

Optional Feature:
- FMUL_ARB_STATS_EN defined: adds output port stat_issued (32 bits), the count of S1 loads; and stat_stall (32 bits), the count of cycles with any req_valid=1 but req_ready all 0.
  - Both counters reset to 0 on rst and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: requester 0 issues x1=0x3FC00000, x2=0x40000000 (1.5*2.0), res_ready=1 → two edges later res_valid=1, res_y=0x40400000, res_ovf=0, res_id=0.
- Overflow: requester 1 issues x1=0x7F000000, x2=0x7F000000 → res_ovf=1, res_y[30:23]=255, res_id=1. Underflow: x1=x2=0x00800000 → res_y=0.
- Round robin: both requesters held valid for 6 cycles, res_ready=1 → grant sequence 0,1,0,1,0,1; res_id follows the same order two cycles later.
- Backpressure: 3 back-to-back requests with res_ready=0 → exactly 2 accepted, then req_ready=0 and res_y stable. Raise res_ready → third request accepted in that cycle; all 3 results appear in order with no loss or duplication.
- Reset mid-operation: rst asserted with S1 and S2 full → next cycle res_valid=0, rr_ptr=0; the first post-reset grant with all requesters valid goes to requester 0.
- Random: 10k random normal operands (exponents 1..254) from random requesters with random res_ready → each result within ±1 ulp of the $shortrealtobits reference (or 0 when the reference exponent is 0), ovf matches, per-requester order preserved.
